// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// stage bit positions in stall/flush vectors, and zero constants.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WAIT_EX  = 2'd2,
        ST_SQUASH   = 2'd3
    } pipe_state_e;

    localparam int NUM_STG   = 5;
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_WB    = 4;

    localparam int CNT_W = 3;

    localparam logic [4:0]  ZERO_REG = 5'd0;
    localparam logic [31:0] ZERO     = 32'd0;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use comparator: flags a load in EX whose destination is read by the
// instruction in ID. x0 never creates a hazard.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_re,
    input  logic       id_rs2_re,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_re && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_re && (id_rs2 == ex_rd);
    assign load_use = ex_is_load && (ex_rd != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush sequencer with registered PC redirect.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
//
// state       | meaning
// ST_RUN      | no hazard outstanding
// ST_WAIT_MEM | data bus wait, whole pipe held, MEM/WB bubbled
// ST_WAIT_EX  | multi-cycle EX unit busy, front end held, EX/MEM bubbled
// ST_SQUASH   | wrong-path fetches in flight, IF/ID bubbled
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_rs1_re_i,
    input  logic              id_rs2_re_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              ex_busy_i,
    input  logic              mem_wait_i,
    input  logic              ex_jump_i,
    input  logic [XLEN-1:0]   ex_jump_addr_i,
    output logic [NUM_STG-1:0] stall_o,
    output logic [NUM_STG-1:0] flush_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_addr_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       perf_stall_cyc_o,
    output logic [31:0]       perf_flush_cnt_o,
    output logic [31:0]       perf_ldu_cnt_o,
`endif
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             jump_acc;
    logic             ldu_acc;

    pipe_hazard_det u_hazard_det (
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .id_rs1_re  (id_rs1_re_i),
        .id_rs2_re  (id_rs2_re_i),
        .ex_rd      (ex_rd_i),
        .ex_is_load (ex_is_load_i),
        .load_use   (load_use)
    );

    // A non-zero counter means squash cycles are still owed; waits hold it so
    // the squash resumes exactly where it stopped.
    always_comb begin
        stall_o  = '0;
        flush_o  = '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        jump_acc = 1'b0;
        ldu_acc  = 1'b0;
        if (!rst_i) begin
            flush_o = '1;
        end else if (mem_wait_i) begin
            stall_o[STG_PC]    = 1'b1;
            stall_o[STG_IFID]  = 1'b1;
            stall_o[STG_IDEX]  = 1'b1;
            stall_o[STG_EXMEM] = 1'b1;
            flush_o[STG_WB]    = 1'b1;
            state_d            = ST_WAIT_MEM;
        end else if (ex_busy_i) begin
            stall_o[STG_PC]    = 1'b1;
            stall_o[STG_IFID]  = 1'b1;
            stall_o[STG_IDEX]  = 1'b1;
            flush_o[STG_EXMEM] = 1'b1;
            state_d            = ST_WAIT_EX;
        end else if (ex_jump_i) begin
            flush_o[STG_IFID] = 1'b1;
            flush_o[STG_IDEX] = 1'b1;
            jump_acc          = 1'b1;
            cnt_d             = CNT_LOAD;
            state_d           = (FLUSH_CYCLES > 1) ? ST_SQUASH : ST_RUN;
        end else if (cnt_q != '0) begin
            flush_o[STG_IFID] = 1'b1;
            cnt_d             = cnt_q - CNT_ONE;
            state_d           = (cnt_q == CNT_ONE) ? ST_RUN : ST_SQUASH;
        end else if (load_use) begin
            stall_o[STG_PC]   = 1'b1;
            stall_o[STG_IFID] = 1'b1;
            flush_o[STG_IDEX] = 1'b1;
            ldu_acc           = 1'b1;
            state_d           = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= ST_RUN;
            cnt_q           <= '0;
            redirect_o      <= 1'b0;
            redirect_addr_o <= XLEN'(ZERO);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_o <= jump_acc;
            if (jump_acc) begin
                redirect_addr_o <= ex_jump_addr_i;
            end
        end
    end

    assign busy_o = (state_q != ST_RUN);

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_stall_cyc_o <= '0;
            perf_flush_cnt_o <= '0;
            perf_ldu_cnt_o   <= '0;
        end else begin
            if ((|stall_o) && (perf_stall_cyc_o != '1)) begin
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            end
            if (jump_acc && (perf_flush_cnt_o != '1)) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            end
            if (ldu_acc && (perf_ldu_cnt_o != '1)) begin
                perf_ldu_cnt_o <= perf_ldu_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic        id_rs1_re_i = 1'b0, id_rs2_re_i = 1'b0;
    logic        ex_is_load_i = 1'b0, ex_busy_i = 1'b0;
    logic        mem_wait_i = 1'b0, ex_jump_i = 1'b0;
    logic [31:0] ex_jump_addr_i = '0;
    logic [4:0]  stall_o, flush_o;
    logic        redirect_o, busy_o;
    logic [31:0] redirect_addr_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc_o, perf_flush_cnt_o, perf_ldu_cnt_o;
`endif

    pipe_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_rs1_re_i     (id_rs1_re_i),
        .id_rs2_re_i     (id_rs2_re_i),
        .ex_rd_i         (ex_rd_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_busy_i       (ex_busy_i),
        .mem_wait_i      (mem_wait_i),
        .ex_jump_i       (ex_jump_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cyc_o(perf_stall_cyc_o),
        .perf_flush_cnt_o(perf_flush_cnt_o),
        .perf_ldu_cnt_o  (perf_ldu_cnt_o),
`endif
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst, mw, eb, jmp;
        logic [31:0] ja;
        logic        ld;
        logic [4:0]  rd, rs1, rs2;
        logic        re1, re2;
    } in_t;

    typedef struct {
        logic [4:0]  stall, flush;
        logic        redir;
        logic [31:0] addr;
        logic        busy;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic in_t idle_in();
        in_t v;
        v.rst = 1'b1; v.mw = 1'b0; v.eb = 1'b0; v.jmp = 1'b0; v.ja = '0;
        v.ld = 1'b0; v.rd = '0; v.rs1 = '0; v.rs2 = '0; v.re1 = 1'b0; v.re2 = 1'b0;
        return v;
    endfunction

    task automatic cyc(input string nm, input in_t v, input logic [4:0] es,
                       input logic [4:0] ef, input logic er, input logic [31:0] ea,
                       input logic eb);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i = v.rst; mem_wait_i = v.mw; ex_busy_i = v.eb; ex_jump_i = v.jmp;
        ex_jump_addr_i = v.ja; ex_is_load_i = v.ld; ex_rd_i = v.rd;
        id_rs1_i = v.rs1; id_rs1_re_i = v.re1; id_rs2_i = v.rs2; id_rs2_re_i = v.re2;
        e.stall = es; e.flush = ef; e.redir = er; e.addr = ea; e.busy = eb;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                total++;
                if ({stall_o, flush_o, redirect_o, redirect_addr_o, busy_o} !==
                    {e.stall, e.flush, e.redir, e.addr, e.busy}) begin
                    bad++;
                    $display("FAIL %s: got stall=%b flush=%b redir=%b addr=%h busy=%b want stall=%b flush=%b redir=%b addr=%h busy=%b",
                             nm, stall_o, flush_o, redirect_o, redirect_addr_o, busy_o,
                             e.stall, e.flush, e.redir, e.addr, e.busy);
                end
            end
        end
    end

    initial begin
        in_t v;

        v = idle_in(); v.rst = 1'b0;
        repeat (3) cyc("reset", v, 5'b00000, 5'b11111, 1'b0, 32'h0, 1'b0);
        v = idle_in();
        cyc("run_idle", v, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        v.ld = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.re2 = 1'b1;
        cyc("ldu_rs2", v, 5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0);
        v.rd = 5'd0; v.rs2 = 5'd0;
        cyc("ldu_x0", v, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
        v = idle_in(); v.ld = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.re1 = 1'b0;
        cyc("ldu_no_re", v, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
        v.re1 = 1'b1;
        cyc("ldu_rs1", v, 5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0);
        v.ld = 1'b0;
        cyc("no_load", v, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        v = idle_in(); v.jmp = 1'b1; v.ja = 32'h100;
        cyc("jump", v, 5'b00000, 5'b00110, 1'b0, 32'h0, 1'b0);
        v = idle_in();
        cyc("squash", v, 5'b00000, 5'b00010, 1'b1, 32'h100, 1'b1);
        cyc("post_squash", v, 5'b00000, 5'b00000, 1'b0, 32'h100, 1'b0);

        v.mw = 1'b1; v.jmp = 1'b1; v.ja = 32'h200;
        cyc("memw_first", v, 5'b01111, 5'b10000, 1'b0, 32'h100, 1'b0);
        repeat (3) cyc("memw_hold", v, 5'b01111, 5'b10000, 1'b0, 32'h100, 1'b1);
        v.mw = 1'b0;
        cyc("jump_after_mem", v, 5'b00000, 5'b00110, 1'b0, 32'h100, 1'b1);
        v = idle_in();
        cyc("squash_after_mem", v, 5'b00000, 5'b00010, 1'b1, 32'h200, 1'b1);
        cyc("run_after_mem", v, 5'b00000, 5'b00000, 1'b0, 32'h200, 1'b0);

        v.eb = 1'b1;
        cyc("exbusy_first", v, 5'b00111, 5'b01000, 1'b0, 32'h200, 1'b0);
        repeat (32) cyc("exbusy_hold", v, 5'b00111, 5'b01000, 1'b0, 32'h200, 1'b1);
        v = idle_in();
        cyc("exbusy_release", v, 5'b00000, 5'b00000, 1'b0, 32'h200, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
        // 2 load-use + 4 mem-wait + 33 ex-busy stalled cycles so far
        total++;
        if (perf_stall_cyc_o !== 32'd39) begin
            bad++;
            $display("FAIL perf_stall_cyc: got %0d want 39", perf_stall_cyc_o);
        end
        total++;
        if (perf_flush_cnt_o !== 32'd2) begin
            bad++;
            $display("FAIL perf_flush_cnt: got %0d want 2", perf_flush_cnt_o);
        end
        total++;
        if (perf_ldu_cnt_o !== 32'd2) begin
            bad++;
            $display("FAIL perf_ldu_cnt: got %0d want 2", perf_ldu_cnt_o);
        end
`endif
        cyc("idle_after_busy", v, 5'b00000, 5'b00000, 1'b0, 32'h200, 1'b0);

        v.jmp = 1'b1; v.ja = 32'h300;
        cyc("jump_a", v, 5'b00000, 5'b00110, 1'b0, 32'h200, 1'b0);
        v.ja = 32'h400;
        cyc("jump_b_in_squash", v, 5'b00000, 5'b00110, 1'b1, 32'h300, 1'b1);
        v = idle_in();
        cyc("squash_b", v, 5'b00000, 5'b00010, 1'b1, 32'h400, 1'b1);
        cyc("run_after_b", v, 5'b00000, 5'b00000, 1'b0, 32'h400, 1'b0);

        v.jmp = 1'b1; v.ja = 32'h500;
        cyc("jump_c", v, 5'b00000, 5'b00110, 1'b0, 32'h400, 1'b0);
        v = idle_in(); v.mw = 1'b1;
        cyc("memw_in_squash", v, 5'b01111, 5'b10000, 1'b1, 32'h500, 1'b1);
        v.mw = 1'b0;
        cyc("squash_resume", v, 5'b00000, 5'b00010, 1'b0, 32'h500, 1'b1);
        cyc("run_after_resume", v, 5'b00000, 5'b00000, 1'b0, 32'h500, 1'b0);

        v.jmp = 1'b1; v.ja = 32'h600;
        cyc("jump_d", v, 5'b00000, 5'b00110, 1'b0, 32'h500, 1'b0);
        v = idle_in(); v.rst = 1'b0;
        cyc("reset_mid_squash", v, 5'b00000, 5'b11111, 1'b0, 32'h0, 1'b0);
        v = idle_in();
        cyc("after_reset", v, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);
        cyc("after_reset2", v, 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        repeat (2) @(posedge clk_i);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
